// File: rtl/wifi_boot_sequencer.sv
// WiFi module boot sequencer: pulses the module reset, then waits for the "ready" token with retries.
// Optional WIFI_BOOT_AUTOSTART_EN: boot automatically on the first cycle after reset releases.
module wifi_boot_sequencer #(
  parameter int RESET_CYCLES = 500000,
  parameter int BOOT_TIMEOUT = 150000000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       wifi_reset,
  output logic       busy,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_count
);

  localparam int TMAX = (RESET_CYCLES > BOOT_TIMEOUT) ? RESET_CYCLES : BOOT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] BOOT_LAST = TW'(BOOT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RST, BOOT, READY, FAIL} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [1:0]    retry_nxt;
  logic          go;

`ifdef WIFI_BOOT_AUTOSTART_EN
  // High for the last reset cycle's successor only: the first free-running cycle.
  logic first;
  always_ff @(posedge clk) first <= reset;
  assign go = start | first;
`else
  assign go = start;
`endif

  function automatic logic [7:0] tok(input logic [2:0] i);
    case (i)
      3'd0:    tok = 8'h72;
      3'd1:    tok = 8'h65;
      3'd2:    tok = 8'h61;
      3'd3:    tok = 8'h64;
      default: tok = 8'h79;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      retry_count <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      idx         <= idx_nxt;
      retry_count <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    retry_nxt = retry_count;
    case (state)
      IDLE, READY, FAIL: begin
        if (go) begin
          state_nxt = RST;
          timer_nxt = '0;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      end
      RST: begin
        if (timer == RST_LAST) begin
          state_nxt = BOOT;
          timer_nxt = '0;
          idx_nxt   = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      BOOT: begin
        timer_nxt = timer + TW'(1);
        if (rx_valid) begin
          if (rx_data == tok(idx))  idx_nxt = idx + 3'd1;
          else if (rx_data == 8'h72) idx_nxt = 3'd1;
          else                       idx_nxt = 3'd0;
        end
        // A token completing on the timeout cycle takes priority over the retry.
        if (rx_valid && idx == 3'd4 && rx_data == 8'h79) begin
          state_nxt = READY;
          timer_nxt = '0;
          idx_nxt   = '0;
        end else if (timer == BOOT_LAST) begin
          timer_nxt = '0;
          idx_nxt   = '0;
          if (int'(retry_count) < MAX_RETRIES) begin
            state_nxt = RST;
            retry_nxt = (retry_count == 2'd3) ? 2'd3 : retry_count + 2'd1;
          end else begin
            state_nxt = FAIL;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wifi_reset = (state != RST);
  assign busy       = (state == RST) || (state == BOOT);
  assign ready      = (state == READY);
  assign fail       = (state == FAIL);

endmodule

// File: tb/tb_wifi_boot_sequencer.sv
// Directed bench for wifi_boot_sequencer with RESET_CYCLES=4, BOOT_TIMEOUT=100, MAX_RETRIES=2.
module tb_wifi_boot_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, rx_valid;
  logic [7:0] rx_data;
  logic       wifi_reset, busy, ready, fail;
  logic [1:0] retry_count;
  int         n_pass = 0;
  int         n_chk  = 0;

  wifi_boot_sequencer #(.RESET_CYCLES(4), .BOOT_TIMEOUT(100), .MAX_RETRIES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .wifi_reset(wifi_reset), .busy(busy), .ready(ready), .fail(fail), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_ready;
    send_byte(8'h72); send_byte(8'h65); send_byte(8'h61); send_byte(8'h64); send_byte(8'h79);
  endtask

  task automatic wait_boot;
    int n = 0;
    while (!wifi_reset && n < 50) begin
      tick();
      n++;
    end
    n_chk++;
    if (wifi_reset !== 1'b1) $display("FAIL wait_boot: wifi_reset=%b required 1 within 50 cycles", wifi_reset);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    start = 1'b0;
    n_chk++; if ({wifi_reset, busy, ready, fail, retry_count} !== 6'b100000)
      $display("FAIL reset_outputs: got %b required 100000", {wifi_reset, busy, ready, fail, retry_count});
    else n_pass++;
    reset = 1'b0;
    tick();
`ifdef WIFI_BOOT_AUTOSTART_EN
    n_chk++; if (wifi_reset !== 1'b0) $display("FAIL autostart: wifi_reset=%b required 0", wifi_reset);
    else n_pass++;
    wait_boot();
    send_ready();
`else
    tick(5);
    n_chk++; if ({wifi_reset, busy} !== 2'b10)
      $display("FAIL stay_idle: wifi_reset,busy=%b required 10", {wifi_reset, busy});
    else n_pass++;
`endif
  endtask

  task automatic test_basic_ready;
    int n = 0;
    do_start();
    while (!wifi_reset && n < 20) begin
      n++;
      start = (n == 2);  // ignored while in RST
      tick();
    end
    start = 1'b0;
    n_chk++; if (n !== 4) $display("FAIL rst_len: low cycles=%0d required 4", n);
    else n_pass++;
    tick(20);
    send_byte(8'h72); send_byte(8'h65); send_byte(8'h61); send_byte(8'h64);
    n_chk++; if ({ready, busy} !== 2'b01) $display("FAIL pre_y: ready,busy=%b required 01", {ready, busy});
    else n_pass++;
    send_byte(8'h79);
    n_chk++; if ({wifi_reset, busy, ready, fail, retry_count} !== 6'b101000)
      $display("FAIL basic_ready: got %b required 101000", {wifi_reset, busy, ready, fail, retry_count});
    else n_pass++;
  endtask

  task automatic test_partial;
    do_start();
    n_chk++; if ({ready, busy} !== 2'b01) $display("FAIL restart_clr: ready,busy=%b required 01", {ready, busy});
    else n_pass++;
    wait_boot();
    send_byte(8'h72); send_byte(8'h72); send_byte(8'h65); send_byte(8'h61); send_byte(8'h64);
    n_chk++; if (ready !== 1'b0) $display("FAIL rready_early: ready=%b required 0", ready);
    else n_pass++;
    send_byte(8'h79);
    n_chk++; if (ready !== 1'b1) $display("FAIL rready: ready=%b required 1", ready);
    else n_pass++;
    do_start();
    wait_boot();
    send_byte(8'h72); send_byte(8'h65); send_byte(8'h61);
    tick(5);
    send_byte(8'h64);
    n_chk++; if (ready !== 1'b0) $display("FAIL gap_early: ready=%b required 0", ready);
    else n_pass++;
    send_byte(8'h79);
    n_chk++; if (ready !== 1'b1) $display("FAIL gap_ready: ready=%b required 1", ready);
    else n_pass++;
    do_start();
    wait_boot();
    send_byte(8'h72); send_byte(8'h65); send_byte(8'h78);
    send_byte(8'h61); send_byte(8'h64); send_byte(8'h79);
    n_chk++; if ({ready, busy} !== 2'b01) $display("FAIL mismatch: ready,busy=%b required 01", {ready, busy});
    else n_pass++;
    send_ready();
    n_chk++; if (ready !== 1'b1) $display("FAIL after_mismatch: ready=%b required 1", ready);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int n = 1;
    int pulses = 1;
    logic prev;
    logic [1:0] rec[3];
    do_start();
    rec[0] = retry_count;
    while (!fail && n < 1000) begin
      prev = wifi_reset;
      tick();
      n++;
      if (prev && !wifi_reset) begin
        if (pulses < 3) rec[pulses] = retry_count;
        pulses++;
      end
    end
    n_chk++; if (n !== 313) $display("FAIL fail_time: cycles=%0d required 313", n);
    else n_pass++;
    n_chk++; if (pulses !== 3) $display("FAIL pulses: got %0d required 3", pulses);
    else n_pass++;
    n_chk++; if ({rec[0], rec[1], rec[2]} !== 6'b000110)
      $display("FAIL retry_seq: got %0d,%0d,%0d required 0,1,2", rec[0], rec[1], rec[2]);
    else n_pass++;
    n_chk++; if ({wifi_reset, busy, ready, fail, retry_count} !== 6'b100110)
      $display("FAIL fail_state: got %b required 100110", {wifi_reset, busy, ready, fail, retry_count});
    else n_pass++;
    do_start();
    n_chk++; if ({busy, fail, retry_count} !== 4'b1000)
      $display("FAIL fail_restart: busy,fail,retry=%b required 1000", {busy, fail, retry_count});
    else n_pass++;
  endtask

  task automatic test_boundary;
    wait_boot();
    tick(95);
    send_ready();  // 'y' lands on timer cycle 99
    n_chk++; if ({wifi_reset, ready, retry_count} !== 4'b1100)
      $display("FAIL y_at_99: wifi_reset,ready,retry=%b required 1100", {wifi_reset, ready, retry_count});
    else n_pass++;
    do_start();
    wait_boot();
    tick(96);
    send_byte(8'h72); send_byte(8'h65); send_byte(8'h61); send_byte(8'h64);
    n_chk++; if ({wifi_reset, ready, retry_count} !== 4'b0001)
      $display("FAIL y_late: wifi_reset,ready,retry=%b required 0001", {wifi_reset, ready, retry_count});
    else n_pass++;
    send_byte(8'h79);  // ignored in RST
    wait_boot();
    send_byte(8'h79);
    n_chk++; if ({ready, busy} !== 2'b01) $display("FAIL partial_dropped: ready,busy=%b required 01", {ready, busy});
    else n_pass++;
  endtask

  task automatic test_start_in_boot;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if ({wifi_reset, busy} !== 2'b11)
      $display("FAIL start_in_boot: wifi_reset,busy=%b required 11", {wifi_reset, busy});
    else n_pass++;
    tick(3);
    send_ready();
    n_chk++; if ({ready, retry_count} !== 3'b101)
      $display("FAIL boot_ready: ready,retry=%b required 101", {ready, retry_count});
    else n_pass++;
  endtask

  task automatic test_reset_mid_rst;
    do_start();
    wait_boot();
    tick(100);
    n_chk++; if ({wifi_reset, retry_count} !== 3'b001)
      $display("FAIL retry_rst: wifi_reset,retry=%b required 001", {wifi_reset, retry_count});
    else n_pass++;
    tick();
    reset = 1'b1; start = 1'b1;
    tick();
    n_chk++; if ({wifi_reset, busy, ready, fail, retry_count} !== 6'b100000)
      $display("FAIL reset_mid_rst: got %b required 100000", {wifi_reset, busy, ready, fail, retry_count});
    else n_pass++;
    reset = 1'b0; start = 1'b0;
    tick();
`ifdef WIFI_BOOT_AUTOSTART_EN
    n_chk++; if (wifi_reset !== 1'b0) $display("FAIL autostart2: wifi_reset=%b required 0", wifi_reset);
    else n_pass++;
`else
    tick(3);
    n_chk++; if ({wifi_reset, busy} !== 2'b10)
      $display("FAIL idle_after_rst: wifi_reset,busy=%b required 10", {wifi_reset, busy});
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic_ready();
    test_partial();
    test_timeout();
    test_boundary();
    test_start_in_boot();
    test_reset_mid_rst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
